// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial two's-complement adder/subtractor
//
// Purpose:
//   Adds or subtracts two WIDTH-bit operands using one DIGIT-bit ripple slice.
//   The slice is reused over WIDTH/DIGIT cycles.
//   Optional macro ADD_SUB_SAT_EN: on signed overflow, RESULT saturates to the
//   signed max/min instead of wrapping.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits resolved per clock; must divide WIDTH
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   START     request, sampled only in IDLE
//   Choice    0 = A+B, 1 = A-B (sampled with START)
//   A, B      operands (sampled with START)
//   BUSY      high while the operation is running
//   DONE      one-cycle pulse, RESULT and flags valid
//   RESULT    sum/difference, held until the next accepted START
//   CARRY     carry out of the MSB (subtraction: 1 = no borrow)
//   OVERFLOW  signed overflow
//   ZERO      RESULT == 0

module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             START,
    input  logic             Choice,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic             c;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;

    logic             last_digit;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] acc_next;
    logic             fin_ovf;
    logic [WIDTH-1:0] fin_result;

    assign last_digit = (count == CW'(N - 1));

    // One ripple slice: low digit of each operand plus the running carry.
    assign digit_sum = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + (DIGIT+1)'(c);

    // New digit enters at the MSB end, so after N shifts the LSB digit has
    // reached the bottom. Written as a wide shift so DIGIT == WIDTH also works.
    assign acc_next = WIDTH'({digit_sum[DIGIT-1:0], acc} >> DIGIT);

    // Sign rule uses the sign bits captured at START (B already inverted for
    // subtraction), so the check is the same for add and subtract.
    assign fin_ovf = (a_msb == b_msb) && (acc[WIDTH-1] != a_msb);

    always_comb begin
        fin_result = acc;
`ifdef ADD_SUB_SAT_EN
        if (fin_ovf) begin
            fin_result = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (START) next_state = S_RUN;
            S_RUN:   if (last_digit) next_state = S_FIN;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa       <= '0;
            sb       <= '0;
            acc      <= '0;
            c        <= 1'b0;
            count    <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            CARRY    <= 1'b0;
            OVERFLOW <= 1'b0;
            ZERO     <= 1'b1;
        end else begin
            // Registered status lags the state by one edge, which places BUSY
            // and DONE on the cycles after the edge that did the work.
            BUSY <= (state == S_RUN);
            DONE <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B, seed carry with 1.
                        sa    <= A;
                        sb    <= B ^ {WIDTH{Choice}};
                        c     <= Choice;
                        count <= '0;
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1] ^ Choice;
                    end
                end
                S_RUN: begin
                    c     <= digit_sum[DIGIT];
                    acc   <= acc_next;
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    count <= count + 1'b1;
                end
                S_FIN: begin
                    RESULT   <= fin_result;
                    CARRY    <= c;
                    OVERFLOW <= fin_ovf;
                    ZERO     <= ~|fin_result;
                end
                default: ;
            endcase
        end
    end

endmodule
